alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Upstream feeder for the 6-bit combinational ALU: accepts operation requests (A, B, fxn)
//  over a valid/ready handshake and buffers them in a small FIFO. Issues one op per cycle to
//  the ALU via registered operand ports, captures the ALU result X into a response register,
//  and presents it downstream with valid/ready. Does not instantiate the ALU; it sits beside it.
// PARAMETERS
//  DEPTH   4   request FIFO entries; power of 2, >=2
//  DW      6   operand/result width (from alu_pkg::ALU_DW)
//  FW      3   function-code width (from alu_pkg::ALU_FW)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   FIFO can accept (= !full)
//  req_a      in   DW  operand A
//  req_b      in   DW  operand B
//  req_fxn    in   FW  ALU function code, passed through unmodified
//  alu_a      out  DW  registered operand A to ALU
//  alu_b      out  DW  registered operand B to ALU
//  alu_fxn    out  FW  registered function to ALU
//  alu_x      in   DW  combinational ALU result
//  rsp_valid  out  1   result present
//  rsp_ready  in   1   downstream accepts result
//  rsp_x      out  DW  captured result
//  rsp_fxn    out  FW  function code that produced rsp_x
//  fifo_level out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO pointers 0, ISS/RSP valid 0; alu_a/alu_b/alu_fxn/rsp_x/rsp_fxn = 0;
//    rsp_valid=0; req_ready=1 once released; fifo_level=0. Reset mid-op discards all in-flight ops.
//  - Push on req_valid&&req_ready; no bypass. Full: req_ready=0, request held by source.
//  - Pipeline: FIFO -> ISS reg (drives alu_*) -> RSP reg. rsp_move = rsp_valid&&rsp_ready.
//    RSP loads {alu_x, alu_fxn} when iss_valid && (!rsp_valid || rsp_move).
//    ISS loads FIFO head when FIFO non-empty && (!iss_valid || RSP loading); pop same edge.
//  - Latency: request accepted at edge N into empty pipe -> alu_* valid after N+1 -> rsp_valid after N+2.
//  - Throughput 1 op/cycle when rsp_ready held high; stalls propagate back with no loss or duplication.
//  - Empty FIFO with push and no pop: level +1. Push and pop same edge: level unchanged.
//  - Pointers wrap modulo DEPTH; extra MSB distinguishes full vs empty.
//  - alu_* hold their last value while ISS is empty or stalled; ALU result stable during stall.
//  - Ops complete strictly in request order.
// CONFIGURATION
//  RESULT_FWD_EN defined: extra input req_fwd_a (1b) stored per entry. When set at issue,
//    alu_a = most recent result: alu_x if an older op is in ISS and moving to RSP that edge,
//    else rsp_x-history register last_x (updated on every RSP load, reset 0). req_a ignored.
//  RESULT_FWD_EN undefined: no req_fwd_a port, no last_x register; alu_a always from req_a.
// STRUCTURE
//  alu_pkg: ALU_DW=6, ALU_FW=3, typedef struct packed {a, b, fxn[, fwd_a]} alu_req_t.
//  Sub-module alu_req_fifo (parameterised DEPTH, payload alu_req_t, push/pop/full/empty/level).
//  Top holds ISS/RSP registers, advance logic, forwarding mux.
// TESTING (bench ALU stub: alu_x = alu_a ^ alu_b)
//  1. Single op A=011001 B=101010 fxn=000, rsp_ready=1 -> rsp_valid 2 cycles later, rsp_x=110011, rsp_fxn=000.
//  2. rsp_ready=0, push 6 ops (DEPTH=4) -> req_ready drops after 6 accepted (4 FIFO+ISS+RSP), level=4;
//     release -> 6 results in order, none lost.
//  3. Back-to-back 8 ops, rsp_ready=1 -> one rsp_valid per cycle, results in order, level<=1.
//  4. rst_n low mid-stream with 3 ops in flight -> all outputs 0 immediately, no rsp after release.
//  5. Toggle rsp_ready every cycle over 10 ops -> rsp_x/rsp_fxn stable while rsp_valid&&!rsp_ready.
//  6. RESULT_FWD_EN: op1 A=000101 B=001100 -> 001001; op2 fwd_a=1 B=000011 back-to-back -> 001010.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths and request payload for the ALU issue stage.
// Optional feature macro: RESULT_FWD_EN adds a per-request "forward previous result as A" flag.
package alu_pkg;

  localparam int ALU_DW = 6;
  localparam int ALU_FW = 3;

  typedef struct packed {
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    logic [ALU_FW-1:0] fxn;
`ifdef RESULT_FWD_EN
    logic              fwd_a;
`endif
  } alu_req_t;

endpackage

// File: rtl/alu_req_fifo.sv
// Request FIFO for the ALU issue stage: DEPTH entries of alu_req_t, pointers with an extra wrap bit.
// Caller guarantees push only when !full_o and pop only when !empty_o.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  alu_req_t                 data_i,
  input  logic                     pop_i,
  output alu_req_t                 data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  alu_req_t        mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;

  // NOTE: storage has no reset; an entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Feeds a combinational ALU: request FIFO -> ISS register (drives alu_*) -> RSP register.
// Optional feature macro: RESULT_FWD_EN (req_fwd_a selects the most recent result as operand A).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ALU_DW-1:0]        req_a,
  input  logic [ALU_DW-1:0]        req_b,
  input  logic [ALU_FW-1:0]        req_fxn,
`ifdef RESULT_FWD_EN
  input  logic                     req_fwd_a,
`endif
  output logic [ALU_DW-1:0]        alu_a,
  output logic [ALU_DW-1:0]        alu_b,
  output logic [ALU_FW-1:0]        alu_fxn,
  input  logic [ALU_DW-1:0]        alu_x,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ALU_DW-1:0]        rsp_x,
  output logic [ALU_FW-1:0]        rsp_fxn,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int DW = ALU_DW;
  localparam int FW = ALU_FW;

  alu_req_t          push_req;
  alu_req_t          head_req;
  logic              fifo_full, fifo_empty;
  logic              push, rsp_move, rsp_load, iss_load;
  logic [DW-1:0]     iss_a;

  logic              iss_valid_q, iss_valid_d;
  logic [DW-1:0]     alu_a_q, alu_a_d;
  logic [DW-1:0]     alu_b_q, alu_b_d;
  logic [FW-1:0]     alu_fxn_q, alu_fxn_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_x_q, rsp_x_d;
  logic [FW-1:0]     rsp_fxn_q, rsp_fxn_d;

  always_comb begin
    push_req       = '0;
    push_req.a     = req_a;
    push_req.b     = req_b;
    push_req.fxn   = req_fxn;
`ifdef RESULT_FWD_EN
    push_req.fwd_a = req_fwd_a;
`endif
  end

  assign push = req_valid && !fifo_full;

  alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_req),
    .pop_i   (iss_load),
    .data_o  (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // A stage may load when it is empty or when its current occupant leaves on the same edge.
  assign rsp_move = rsp_valid_q && rsp_ready;
  assign rsp_load = iss_valid_q && (!rsp_valid_q || rsp_move);
  assign iss_load = !fifo_empty && (!iss_valid_q || rsp_load);

`ifdef RESULT_FWD_EN
  logic [DW-1:0] last_x_q;

  // The op in ISS moving to RSP this edge is the newest result; otherwise last_x already holds it.
  always_comb begin
    iss_a = head_req.a;
    if (head_req.fwd_a) iss_a = rsp_load ? alu_x : last_x_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_x_q <= '0;
    else if (rsp_load) last_x_q <= alu_x;
  end
`else
  assign iss_a = head_req.a;
`endif

  // NOTE: combinational next-state uses blocking '=' with defaults first, so no latches form.
  always_comb begin
    iss_valid_d = iss_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fxn_d   = alu_fxn_q;
    rsp_valid_d = rsp_valid_q;
    rsp_x_d     = rsp_x_q;
    rsp_fxn_d   = rsp_fxn_q;

    if (iss_load) begin
      iss_valid_d = 1'b1;
      alu_a_d     = iss_a;
      alu_b_d     = head_req.b;
      alu_fxn_d   = head_req.fxn;
    end else if (rsp_load) begin
      iss_valid_d = 1'b0;
    end

    if (rsp_load) begin
      rsp_valid_d = 1'b1;
      rsp_x_d     = alu_x;
      rsp_fxn_d   = alu_fxn_q;
    end else if (rsp_move) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fxn_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_x_q     <= '0;
      rsp_fxn_q   <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fxn_q   <= alu_fxn_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_x_q     <= rsp_x_d;
      rsp_fxn_q   <= rsp_fxn_d;
    end
  end

  assign req_ready = !fifo_full;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fxn   = alu_fxn_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_fxn   = rsp_fxn_q;

endmodule
